// File: rtl/num_stats_pkg.sv
// Shared types and defaults for the frame statistics block.
package num_stats_pkg;
  typedef enum logic {COLLECT, REPORT} state_t;
  localparam int FRAME_LEN_DEF = 16;
endpackage

// File: rtl/num_stats_if.sv
// Sample-in / report-out handshake bundle for num_stats.
interface num_stats_if
  import num_stats_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF
) ();
  localparam int CW = $clog2(FRAME_LEN + 1);

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    a;
  logic          p;
  logic          d;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] prime_cnt;
  logic [CW-1:0] div_cnt;
  logic [CW-1:0] both_cnt;
  logic [CW-1:0] sample_cnt;
  logic [3:0]    max_val;

  modport master (
    output in_valid, a, p, d, flush, out_ready,
    input  in_ready, out_valid, prime_cnt,
    input  div_cnt, both_cnt, sample_cnt, max_val
  );

  modport slave (
    input  in_valid, a, p, d, flush, out_ready,
    output in_ready, out_valid, prime_cnt,
    output div_cnt, both_cnt, sample_cnt, max_val
  );
endinterface

// File: rtl/num_stats.sv
// Per-frame counts of prime / div-by-3 samples plus max value,
// reported over a valid/ready handshake.
module num_stats
  import num_stats_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  num_stats_if.slave bus
);
  localparam int CW = $clog2(FRAME_LEN + 1);

  state_t        state;
  logic [CW-1:0] n_smp, n_pr, n_dv, n_bt;
  logic [3:0]    mx;

  logic          acc;
  logic          done;
  logic [CW-1:0] smp_nx, pr_nx, dv_nx, bt_nx;
  logic [3:0]    mx_nx;

  always_comb begin
    acc    = bus.in_valid && (state == COLLECT);
    smp_nx = n_smp;
    pr_nx  = n_pr;
    dv_nx  = n_dv;
    bt_nx  = n_bt;
    mx_nx  = mx;
    if (acc) begin
      smp_nx = n_smp + CW'(1);
      pr_nx  = n_pr + CW'(bus.p);
      dv_nx  = n_dv + CW'(bus.d);
      bt_nx  = n_bt + CW'(bus.p & bus.d);
      mx_nx  = (bus.a > mx) ? bus.a : mx;
    end
    // a flush with an empty frame (even after this cycle) is ignored
    done = (state == COLLECT) &&
           ((acc && smp_nx == CW'(FRAME_LEN)) ||
            (bus.flush && smp_nx != '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= COLLECT;
      bus.in_ready   <= 1'b1;
      bus.out_valid  <= 1'b0;
      n_smp          <= '0;
      n_pr           <= '0;
      n_dv           <= '0;
      n_bt           <= '0;
      mx             <= '0;
      bus.sample_cnt <= '0;
      bus.prime_cnt  <= '0;
      bus.div_cnt    <= '0;
      bus.both_cnt   <= '0;
      bus.max_val    <= '0;
    end else begin
      unique case (state)
        COLLECT: begin
          n_smp <= smp_nx;
          n_pr  <= pr_nx;
          n_dv  <= dv_nx;
          n_bt  <= bt_nx;
          mx    <= mx_nx;
          if (done) begin
            bus.sample_cnt <= smp_nx;
            bus.prime_cnt  <= pr_nx;
            bus.div_cnt    <= dv_nx;
            bus.both_cnt   <= bt_nx;
            bus.max_val    <= mx_nx;
            bus.in_ready   <= 1'b0;
            bus.out_valid  <= 1'b1;
            state          <= REPORT;
          end
        end
        REPORT: begin
          if (bus.out_ready) begin
            n_smp         <= '0;
            n_pr          <= '0;
            n_dv          <= '0;
            n_bt          <= '0;
            mx            <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            state         <= COLLECT;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/num_stats.md
NUM_STATS -- requirements
Module: num_stats

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16, meaning samples per full frame (legal range 2..255).
REQ-002 SHALL derive localparam CW = $clog2(FRAME_LEN+1), the width of every count output.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream sample present.
REQ-006 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-007 SHALL have port a  input  4  sample value, 0..15.
REQ-008 SHALL have port p  input  1  upstream classifier prime flag for a.
REQ-009 SHALL have port d  input  1  upstream classifier divisible-by-3 flag for a.
REQ-010 SHALL have port flush  input  1  end current frame early.
REQ-011 SHALL have port out_valid  output  1  frame report present.
REQ-012 SHALL have port out_ready  input  1  downstream takes report.
REQ-013 SHALL have ports prime_cnt, div_cnt, both_cnt, sample_cnt  output  CW each  count of p=1, d=1, p&d=1, and all accepted samples in the reported frame.
REQ-014 SHALL have port max_val  output  4  largest a accepted in the reported frame.

Function
REQ-015 SHALL implement a two-state FSM: COLLECT, REPORT.
REQ-016 In COLLECT: in_ready=1, out_valid=0; in REPORT: in_ready=0, out_valid=1.
REQ-017 A sample is accepted when in_valid && in_ready; p, d, a are used only on acceptance; flags are taken as given, never recomputed from a.
REQ-018 On acceptance, accumulators update: samples+1, primes+p, divs+d, both+(p&d), max=max(max,a).
REQ-019 When the accepted sample is the FRAME_LEN-th, the updated accumulators SHALL be latched into the output registers and the FSM SHALL enter REPORT on the same edge (out_valid high the cycle after the last accepted sample).
REQ-020 flush in COLLECT with ≥1 sample accumulated (counting a sample accepted the same cycle) SHALL end the frame identically to REQ-019, with sample_cnt < FRAME_LEN.
REQ-021 flush with zero samples and no sample accepted that cycle SHALL be ignored; flush in REPORT SHALL be ignored.
REQ-022 In REPORT, all outputs SHALL hold stable until out_valid && out_ready; on that edge the FSM returns to COLLECT and all accumulators clear to 0.
REQ-023 No sample is accepted in the handshake cycle; the earliest next acceptance is the following cycle.
REQ-024 Counts SHALL never wrap: each is bounded by FRAME_LEN ≤ 2^CW-1.
REQ-025 Output registers SHALL change only on frame latch or reset; out_valid SHALL not drop without handshake.

Reset
REQ-026 reset SHALL, on the next rising edge, force COLLECT, clear accumulators, and drive all count outputs, max_val, and out_valid to 0 (in_ready=1 the cycle after).
REQ-027 reset mid-frame or during REPORT SHALL discard the partial frame/pending report; no report is emitted for it.
REQ-028 reset SHALL take priority over in_valid, flush, and out_ready.

Structure
REQ-029 Package num_stats_pkg SHALL hold the state enum typedef (COLLECT, REPORT) and the default FRAME_LEN constant.
REQ-030 No sub-module; FSM, accumulators, and output registers live in num_stats, and the classifier stays a separate upstream instance.

Verification
REQ-031 16 samples a=0..15 back-to-back, p=1 on a∈{2,3,5,7,11,13}, d=1 on a∈{3,6,9,12,15}, out_ready=1 -> one report: prime_cnt=6, div_cnt=5, both_cnt=1, sample_cnt=16, max_val=15, out_valid high exactly one cycle.
REQ-032 3 samples a=4,9,2 (p=0,0,1; d=0,1,0) then flush -> prime_cnt=1, div_cnt=1, both_cnt=0, sample_cnt=3, max_val=9.
REQ-033 Full frame with out_ready=0 for 5 cycles, in_valid held 1 -> in_ready=0 and outputs stable for 5 cycles; after handshake next frame counts start at 0.
REQ-034 flush asserted with no samples, then with in_valid on the same cycle as the 1st sample a=7,p=1 -> first ignored; second reports sample_cnt=1, prime_cnt=1, max_val=7.
REQ-035 reset asserted after 10 samples, then 16 fresh samples all p=0,d=0,a=1 -> only one report, with sample_cnt=16, all flag counts 0, max_val=1.
